// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encodings, frame geometry, parity helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;  // start + 8 data + parity + stop

  // Rx state encodings, binary-coded like the Tx state constants.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  // Returns 1 when the received parity bit disagrees with the expected sense.
  function automatic logic parity_err(input logic [DATA_BITS-1:0] d,
                                      input logic                 p,
                                      input logic                 odd);
    return ((^d) ^ p) != odd;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset to 1 (idle line).
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_uart.sv
// UART receiver: 8N-parity-1 frames, LSB first, oversampled on clk, byte + error flags on a strobe.
// Latency: o_valid CLKS_PER_BIT/2 + 10*CLKS_PER_BIT + 1 cycles after start detect (+2 sync cycles).
// Backpressure: none; consumer must take o_data/flags on the o_valid cycle (held until next strobe).
module rx_uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int OS_CW  = $clog2(CLKS_PER_BIT);
  localparam int BIT_CW = $clog2(DATA_BITS);
  localparam logic [OS_CW-1:0]  OS_MID   = OS_CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [OS_CW-1:0]  OS_LAST  = OS_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_BITS - 1);

  rx_state_t            state, state_nxt;
  logic                 rx;
  logic [OS_CW-1:0]     os_cnt;
  logic [BIT_CW-1:0]    bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 stop_bit;
  logic                 pend;
  logic                 mid;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx)
  );

  // The counter is zero on the start-detect edge, so every mid-bit sample lands on OS_MID.
  assign mid    = (os_cnt == OS_MID);
  assign o_busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; only IDLE looks at enable, so a frame in flight always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable && !rx) state_nxt = START;
      START:     if (mid) state_nxt = rx ? IDLE : DATA;
      DATA:      if (mid && (bit_cnt == BIT_LAST)) state_nxt = PARITY;
      PARITY:    if (mid) state_nxt = STOP;
      STOP:      if (mid) state_nxt = rx ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Oversample counter: held at zero in IDLE, free-running with wrap elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 os_cnt <= '0;
    else if (state == IDLE)    os_cnt <= '0;
    else if (os_cnt == OS_LAST) os_cnt <= '0;
    else                       os_cnt <= os_cnt + 1'b1;
  end

  // Bit counter and sampled frame fields; pend marks the stop sample for the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      stop_bit  <= 1'b1;
      pend      <= 1'b0;
    end else begin
      if (state == START && mid) bit_cnt <= '0;
      if (state == DATA && mid) begin
        bit_cnt   <= bit_cnt + 1'b1;
        shift_reg <= {rx, shift_reg[DATA_BITS-1:1]};
      end
      if (state == PARITY && mid) par_bit  <= rx;
      if (state == STOP && mid)   stop_bit <= rx;
      pend <= (state == STOP) && mid;
    end
  end

  // Output stage: data and flags change only together with the strobe, one cycle after the stop sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= pend;
      if (pend) begin
        o_data       <= shift_reg;
        o_parity_err <= parity_err(shift_reg, par_bit, PARITY_ODD);
        o_frame_err  <= !stop_bit;
      end
    end
  end

endmodule

// File: tb/tb_rx_uart.sv
// Directed bench for rx_uart at 16 clocks per bit, even parity.
// Frames are driven on the falling edge; strobes are logged on the falling edge.
// Expected bytes, flags and latencies are hand-computed constants.
module tb_rx_uart;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       serial_in;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int vcount = 0;
  int busy_cnt = 0;
  int t_start = 0;

  logic [7:0] q_data[$];
  logic       q_pe[$];
  logic       q_fe[$];
  int         q_cyc[$];

  rx_uart #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .serial_in    (serial_in),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  // Edge counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every strobe and count busy cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_valid) begin
      vcount++;
      q_data.push_back(o_data);
      q_pe.push_back(o_parity_err);
      q_fe.push_back(o_frame_err);
      q_cyc.push_back(cyc);
    end
    if (o_busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one frame starting at a falling edge; the line is left at the stop value.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int stop_len);
    serial_in = 1'b0;
    t_start   = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      repeat (CPB) @(negedge clk);
    end
    serial_in = par;
    repeat (CPB) @(negedge clk);
    serial_in = stp;
    repeat (stop_len) @(negedge clk);
  endtask

  // Wait (bounded) for a logged strobe, then check its byte and flags.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe, input logic fe,
                              output int vcyc);
    int w = 0;
    vcyc = -1;
    while (q_data.size() == 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_seen"}, 32'(q_data.size() != 0), 32'd1);
    if (q_data.size() != 0) begin
      chk({tag, "_data"}, 32'(q_data.pop_front()), 32'(d));
      chk({tag, "_perr"}, 32'(q_pe.pop_front()), 32'(pe));
      chk({tag, "_ferr"}, 32'(q_fe.pop_front()), 32'(fe));
      vcyc = q_cyc.pop_front();
    end
  endtask

  initial begin
    int vc;
    int t0;
    reset     = 1'b1;
    enable    = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(o_data), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_perr",  32'(o_parity_err), 32'h0);
    chk("rst_ferr",  32'(o_frame_err), 32'h0);
    chk("rst_busy",  32'(o_busy), 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Clean 0xA5: strobe 3 edges (2 sync + detect) + 169 cycles after the line falls.
    send_frame(8'hA5, 1'b0, 1'b1, CPB);
    t0 = t_start;
    expect_frame("a5", 8'hA5, 1'b0, 1'b0, vc);
    chk("a5_lat", 32'(vc - t0), 32'd172);
    chk("a5_busy", 32'(o_busy), 32'h0);
    chk("a5_cnt", 32'(vcount), 32'd1);
    repeat (20) @(negedge clk);

    // 0x3C has four ones, so parity bit 1 is wrong for even parity.
    send_frame(8'h3C, 1'b1, 1'b1, CPB);
    expect_frame("3c", 8'h3C, 1'b1, 1'b0, vc);
    repeat (20) @(negedge clk);

    // 0x81 with stop bit 0, line held low: framing error, parked in WAIT_IDLE.
    send_frame(8'h81, 1'b0, 1'b0, CPB);
    repeat (40 * CPB) @(negedge clk);
    expect_frame("81", 8'h81, 1'b0, 1'b1, vc);
    chk("81_busy_low", 32'(o_busy), 32'h1);
    chk("81_cnt", 32'(vcount), 32'd3);
    serial_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("81_busy_rel", 32'(o_busy), 32'h0);
    chk("81_cnt_rel", 32'(vcount), 32'd3);

    // 4-cycle glitch: START for 8 cycles then back to IDLE without a strobe.
    busy_cnt  = 0;
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy", 32'(busy_cnt), 32'd8);
    chk("glitch_cnt", 32'(vcount), 32'd3);

    // Back-to-back 0x00 then 0xFF.
    send_frame(8'h00, 1'b0, 1'b1, CPB);
    send_frame(8'hFF, 1'b0, 1'b1, CPB);
    expect_frame("b2b0", 8'h00, 1'b0, 1'b0, vc);
    expect_frame("b2b1", 8'hFF, 1'b0, 1'b0, vc);
    chk("b2b_cnt", 32'(vcount), 32'd5);
    repeat (20) @(negedge clk);

    // enable dropped mid-frame: frame still completes.
    fork
      send_frame(8'hC3, 1'b0, 1'b1, CPB);
      begin
        repeat (40) @(negedge clk);
        enable = 1'b0;
      end
    join
    expect_frame("c3", 8'hC3, 1'b0, 1'b0, vc);
    repeat (20) @(negedge clk);

    // enable low in IDLE: whole frame ignored.
    busy_cnt = 0;
    send_frame(8'h5A, 1'b0, 1'b1, CPB);
    repeat (30) @(negedge clk);
    chk("dis_cnt", 32'(vcount), 32'd6);
    chk("dis_busy", 32'(busy_cnt), 32'd0);
    enable = 1'b1;
    repeat (20) @(negedge clk);

    // Reset during data bit 3 of 0x55 aborts without a strobe.
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      serial_in = i[0] ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    serial_in = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_busy_pre", 32'(o_busy), 32'h1);
    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_busy", 32'(o_busy), 32'h0);
    chk("abort_data", 32'(o_data), 32'h0);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_cnt", 32'(vcount), 32'd6);
    send_frame(8'h55, 1'b0, 1'b1, CPB);
    expect_frame("55", 8'h55, 1'b0, 1'b0, vc);
    chk("55_cnt", 32'(vcount), 32'd7);
    repeat (50) @(negedge clk);
    chk("55_hold", 32'(o_data), 32'h55);
    chk("55_valid_low", 32'(o_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
